// File: rtl/nibble_serial_sub_ctrl.sv
// Serial subtractor controller: computes a - b - bin one 4-bit nibble per
// clock, least-significant nibble first, chaining the borrow in a register.
module nibble_serial_sub_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   bout
);

  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               borrow, borrow_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [WIDTH-1:0]   diff_n;
  logic               bout_n;
  logic               busy_n;
  logic               done_n;

  // Nibble datapath: 5-bit subtract-with-borrow on the selected slice
  logic [IDX_W+1:0]   lsb;
  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [4:0]         sub;

  always_comb begin
    lsb   = {idx, 2'b00};
    a_nib = a_q[lsb +: 4];
    b_nib = b_q[lsb +: 4];
    sub   = {1'b0, a_nib} - {1'b0, b_nib} - 5'(borrow);
  end

  // State and datapath registers; reset clears everything, aborting any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      borrow <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      borrow <= borrow_n;
      a_q    <= a_n;
      b_q    <= b_n;
      diff   <= diff_n;
      bout   <= bout_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next-state and next-register values; busy/done derived from the next state
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    borrow_n = borrow;
    a_n      = a_q;
    b_n      = b_q;
    diff_n   = diff;
    bout_n   = bout;

    case (state)
      IDLE: begin
        if (start) begin
          a_n      = a;
          b_n      = b;
          borrow_n = bin;
          idx_n    = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        diff_n[lsb +: 4] = sub[3:0];
        borrow_n         = sub[4];
        if (idx == IDX_W'(NIBBLES - 1)) begin
          bout_n  = sub[4];
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed and randomized checks for the serial subtractor controller.
module tb_nibble_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done;
  logic [15:0] diff;
  logic        bout;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        bin1;
  logic        busy1, done1;
  logic [3:0]  diff1;
  logic        bout1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_sub_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  nibble_serial_sub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then wait (bounded) for done; lat counts edges after E0
  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic bi_n,
                       output int lat);
    a = ai; b = bi; bin = bi_n; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    logic [16:0] ref17;

    vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].exp_bout));
      tick();
      check($sformatf("vec%0d_hold", i), 32'(diff), 32'(vecs[i].exp_diff));
    end

    // Single-nibble configuration
    a1 = 4'd6; b1 = 4'd2; bin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_e0_done", 32'(done1), 32'd0);
    check("n1_e0_busy", 32'(busy1), 32'd1);
    tick();
    check("n1_done", 32'(done1), 32'd1);
    check("n1_diff", 32'(diff1), 32'd3);
    check("n1_bout", 32'(bout1), 32'd0);
    tick();
    check("n1_idle_busy", 32'(busy1), 32'd0);

    // Busy protection and waveform: second start in 2nd RUN cycle ignored
    a = 16'h1234; b = 16'h0034; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_e0_busy", 32'(busy), 32'd1);
    check("bp_e0_done", 32'(done), 32'd0);
    tick();
    a = 16'hAAAA; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    check("bp_e2_busy", 32'(busy), 32'd1);
    check("bp_e2_done", 32'(done), 32'd0);
    tick();
    check("bp_e3_done", 32'(done), 32'd0);
    tick();
    check("bp_e4_done", 32'(done), 32'd1);
    check("bp_e4_busy", 32'(busy), 32'd1);
    check("bp_diff", 32'(diff), 32'h1200);
    tick();
    check("bp_e5_done", 32'(done), 32'd0);
    check("bp_e5_busy", 32'(busy), 32'd0);

    // Held start: re-accepted on first IDLE edge (E6)
    a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("hold_e4_done", 32'(done), 32'd1);
    tick();
    check("hold_e5_busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    check("hold_e6_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("hold_lat", 32'(lat), 32'd4);
    check("hold_diff", 32'(diff), 32'h0002);
    tick();

    // Reset during the 2nd RUN cycle aborts with no done pulse
    a = 16'h1234; b = 16'h0034; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Reset and start on the same edge: start lost
    a = 16'h00FF; b = 16'h0001; bin = 1'b0; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    check("prio_busy0", 32'(busy), 32'd0);
    tick();
    check("prio_busy1", 32'(busy), 32'd0);
    check("prio_diff", 32'(diff), 32'd0);

    // Randomized regression against a 17-bit reference subtraction
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rbin;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      ref17 = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      do_op(ra, rb, rbin, lat);
      check("rnd_lat", 32'(lat), 32'd4);
      check("rnd_diff", 32'(diff), 32'(ref17[15:0]));
      check("rnd_bout", 32'(bout), 32'(ref17[16]));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub_ctrl.md
# nibble_serial_sub_ctrl

Sequencing controller that performs a WIDTH = 4·NIBBLES bit subtraction by time-multiplexing a single 4-bit subtract-with-borrow stage, one nibble per clock, least-significant nibble first. The borrow is chained between nibbles in an internal register. It sits between a requester issuing start/operand pulses and downstream logic consuming the done/diff/bout result. It reuses the team's 4-bit `{borrow, diff} = A - B - Bin` arithmetic as its datapath.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width is 4·NIBBLES; legal range 1..16.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; takes effect on the clk rising edge where it is sampled high.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  4·NIBBLES  minuend; captured on accepted start.
- b  in  4·NIBBLES  subtrahend; captured on accepted start.
- bin  in  1  borrow-in; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- diff  out  4·NIBBLES  result (a − b − bin) mod 2^(4·NIBBLES).
- bout  out  1  final borrow; 1 iff a < b + bin (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- Reset:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0.
  - Internal nibble index = 0, borrow register = 0.
  - Operand registers = 0.
- IDLE:
  - start = 1 → capture a, b and bin (bin into the borrow register); index = 0; go to RUN.
  - start = 0 → stay in IDLE; diff and bout hold.
- RUN, each cycle:
  - {nb, nd} = a_nib[index] − b_nib[index] − borrow, evaluated 5 bits wide.
  - nd is written into diff[4·index+3 : 4·index]; borrow = nb.
  - If index = NIBBLES−1: bout = nb and go to DONE.
  - Otherwise: index = index + 1.
- DONE: done = 1 for exactly this cycle; next state is IDLE.
- start is ignored in RUN and DONE. There is no queuing; the requester must wait for done.
- diff holds its partial result during RUN. Only the value present while done = 1, or afterwards, is defined as the result.
- diff and bout hold after DONE until the next accepted start.
- Arithmetic is unsigned modular. The internal width is 5 bits per slice. No overflow flag beyond bout.
- Reset mid-operation (RUN or DONE): abort immediately; all outputs return to their reset values; no done pulse.
- rst and start high on the same edge: rst wins and the start is lost.

## Timing
- Edge E0 samples start = 1 in IDLE → RUN from E0. busy rises after E0.
- Edges E1..E(NIBBLES) process nibbles 0..NIBBLES−1.
- After edge E(NIBBLES):
  - done = 1.
  - Final diff and bout are visible.
  - state = DONE.
- After edge E(NIBBLES+1): done = 0, busy = 0, state = IDLE.
- Latency: start to done = NIBBLES cycles. Throughput: one operation per NIBBLES+2 cycles.
- A start held high across DONE is re-accepted at E(NIBBLES+2), because that is the first IDLE edge.
- NIBBLES = 1 degenerates to a single RUN cycle with the same protocol.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use NIBBLES = 4 unless stated.
- Plain subtraction: after reset, pulse start with a = 0x1234, b = 0x0034, bin = 0 → done exactly 4 cycles later; diff = 0x1200, bout = 0.
- Borrow ripple, wrap-around, and borrow-in chain:
  - a = 0x0000, b = 0x0001, bin = 0 → diff = 0xFFFF, bout = 1.
  - a = 0x0010, b = 0x0000, bin = 1 → diff = 0x000F, bout = 0.
- Extreme case and single-nibble configuration:
  - a = 0xFFFF, b = 0xFFFF, bin = 1 → diff = 0xFFFF, bout = 1.
  - With NIBBLES = 1: a = 6, b = 2, bin = 1 → diff = 3, bout = 0, done 1 cycle after start.
- Busy protection:
  - Start 0x1234 − 0x0034.
  - Pulse start with a = 0xAAAA, b = 0x1111 in the 2nd RUN cycle → ignored; result is still 0x1200.
  - Held start → re-accepted on the first IDLE edge.
  - Check busy/done waveform against the Timing section.
- Reset mid-operation: assert rst during the 2nd RUN cycle → next cycle busy = 0, done = 0, diff = 0, bout = 0, no done pulse.
- Reset priority: rst and start high on the same edge → the start is lost.
- Randomized regression: 1000 random a, b and bin values → each done-cycle diff and bout match (a − b − bin) mod 2^16 and the unsigned-borrow reference.
